// File: rtl/led_bank_arbiter.sv
// Time-sliced round-robin arbiter sharing an 8-bit LED bank among 4 requesters.
// Optional macro HEARTBEAT_EN drives a heartbeat on LED7 while idle.
module led_bank_arbiter #(
  parameter int SLICE_W = 22
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  req,
  input  logic [31:0] pat,
  output logic [3:0]  gnt,
  output logic [1:0]  owner,
  output logic        busy,
  output logic        slice_tick,
  output logic [7:0]  LEDS
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [SLICE_W-1:0] CNT_LAST    = {SLICE_W{1'b1}};
  localparam logic [SLICE_W-1:0] CNT_PRELAST = {{(SLICE_W-1){1'b1}}, 1'b0};

  state_t             state_reg;
  logic [SLICE_W-1:0] cnt_reg;
  logic [1:0]         rr_ptr_reg;
  logic [3:0]         gnt_reg;
  logic [1:0]         owner_reg;
  logic               busy_reg;
  logic               tick_reg;
  logic [7:0]         leds_reg;

  logic [3:0]         rot_req;
  logic [7:0]         pat_arr [4];
  logic [1:0]         sel_off;
  logic [1:0]         sel;
  logic [7:0]         idle_leds;
  logic               owner_req;

  // Requests rotated so that index 0 is the current round-robin head.
  for (genvar gi = 0; gi < 4; gi++) begin : g_rot
    assign rot_req[gi] = req[rr_ptr_reg + 2'(gi)];
    assign pat_arr[gi] = pat[8*gi +: 8];
  end

  always_comb begin
    sel_off = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      if (rot_req[k]) sel_off = 2'(k);
    end
  end

  assign sel       = rr_ptr_reg + sel_off;
  assign owner_req = req[owner_reg];

`ifdef HEARTBEAT_EN
  assign idle_leds = {cnt_reg[SLICE_W-1], 7'b0};
`else
  assign idle_leds = 8'h00;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      rr_ptr_reg <= 2'd0;
      gnt_reg    <= 4'b0000;
      owner_reg  <= 2'd0;
      busy_reg   <= 1'b0;
      tick_reg   <= 1'b0;
      leds_reg   <= 8'h00;
    end else begin
      case (state_reg)
        IDLE: begin
          leds_reg <= idle_leds;
          tick_reg <= 1'b0;
          if (req != 4'b0000) begin
            state_reg  <= GRANT;
            gnt_reg    <= 4'b0001 << sel;
            owner_reg  <= sel;
            busy_reg   <= 1'b1;
            cnt_reg    <= '0;
            rr_ptr_reg <= sel + 2'd1;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        GRANT: begin
          if (!owner_req) begin
            // Release has priority over a coincident slice end.
            state_reg <= IDLE;
            gnt_reg   <= 4'b0000;
            busy_reg  <= 1'b0;
            tick_reg  <= 1'b0;
            cnt_reg   <= cnt_reg + 1'b1;
            leds_reg  <= idle_leds;
          end else if (cnt_reg == CNT_LAST) begin
            // Owner sits last in the scan order, so it is re-picked only when alone.
            gnt_reg    <= 4'b0001 << sel;
            owner_reg  <= sel;
            cnt_reg    <= '0;
            rr_ptr_reg <= sel + 2'd1;
            tick_reg   <= 1'b0;
            leds_reg   <= pat_arr[owner_reg];
          end else begin
            cnt_reg  <= cnt_reg + 1'b1;
            tick_reg <= (cnt_reg == CNT_PRELAST);
            leds_reg <= pat_arr[owner_reg];
          end
        end
        default: begin
          state_reg <= IDLE;
          gnt_reg   <= 4'b0000;
          busy_reg  <= 1'b0;
          tick_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign gnt        = gnt_reg;
  assign owner      = owner_reg;
  assign busy       = busy_reg;
  assign slice_tick = tick_reg;
  assign LEDS       = leds_reg;

endmodule

// File: tb/tb_led_bank_arbiter.sv
// Directed bench for led_bank_arbiter with SLICE_W=4 (16-cycle slices), default build.
module tb_led_bank_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req = 4'b0000;
  logic [31:0] pat = 32'h0;
  logic [3:0]  gnt;
  logic [1:0]  owner;
  logic        busy;
  logic        slice_tick;
  logic [7:0]  LEDS;

  int checks = 0;
  int errors = 0;

  led_bank_arbiter #(.SLICE_W(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .pat        (pat),
    .gnt        (gnt),
    .owner      (owner),
    .busy       (busy),
    .slice_tick (slice_tick),
    .LEDS       (LEDS)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  int exp_own [5] = '{0, 1, 3, 0, 1};
  int seg_len [5] = '{15, 15, 15, 15, 5};
  logic [3:0] oh;

  initial begin
    pat = {8'h3C, 8'hA5, 8'h5A, 8'h11};

    // Reset with all requests asserted.
    rst = 1'b1; req = 4'hF;
    step(2);
    check("rst_gnt", 32'(gnt), 32'h0);
    check("rst_leds", 32'(LEDS), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_owner", 32'(owner), 32'h0);
    check("rst_tick", 32'(slice_tick), 32'h0);
    rst = 1'b0;
    step();
    check("post_rst_gnt", 32'(gnt), 32'h1);
    check("post_rst_busy", 32'(busy), 32'h1);

    // Single requester 2 holds the bank across several slices.
    rst = 1'b1; req = 4'b0100;
    step();
    check("single_rst_gnt", 32'(gnt), 32'h0);
    rst = 1'b0;
    step();
    check("single_gnt", 32'(gnt), 32'h4);
    check("single_owner", 32'(owner), 32'h2);
    check("single_leds_first", 32'(LEDS), 32'h0);
    step();
    check("single_leds", 32'(LEDS), 32'hA5);
    for (int k = 2; k <= 40; k++) begin
      step();
      check($sformatf("single_gnt_k%0d", k), 32'(gnt), 32'h4);
      check($sformatf("single_tick_k%0d", k), 32'(slice_tick), 32'((k % 16) == 15));
      check($sformatf("single_leds_k%0d", k), 32'(LEDS), 32'hA5);
    end
    pat[23:16] = 8'hC3;
    step();
    check("pat_change_leds", 32'(LEDS), 32'hC3);
    pat[23:16] = 8'hA5;

    // Rotation among requesters 0, 1 and 3.
    rst = 1'b1; req = 4'b1011;
    step();
    rst = 1'b0;
    step();
    for (int j = 0; j < 5; j++) begin
      oh = 4'(1 << exp_own[j]);
      check($sformatf("rot_gnt_s%0d", j), 32'(gnt), 32'(oh));
      check($sformatf("rot_owner_s%0d", j), 32'(owner), 32'(exp_own[j]));
      check($sformatf("rot_busy_s%0d", j), 32'(busy), 32'h1);
      for (int k = 1; k <= seg_len[j]; k++) begin
        step();
        check($sformatf("rot_hold_s%0d_k%0d", j, k), 32'(gnt), 32'(oh));
        check($sformatf("rot_tick_s%0d_k%0d", j, k), 32'(slice_tick), 32'(k == 15));
      end
      if (j < 4) step();
    end

    // Release by owner 1 mid-slice, then a fresh request from 2.
    req = 4'b1001;
    step();
    check("rel_gnt", 32'(gnt), 32'h0);
    check("rel_busy", 32'(busy), 32'h0);
    check("rel_leds", 32'(LEDS), 32'h0);
    check("rel_owner_hold", 32'(owner), 32'h1);
    req = 4'b0100;
    step();
    check("rel_regrant", 32'(gnt), 32'h4);

    // Release on the slice_tick cycle while requester 2 waits.
    rst = 1'b1; req = 4'b0101;
    step();
    rst = 1'b0;
    step();
    check("sim_gnt0", 32'(gnt), 32'h1);
    step(15);
    check("sim_tick", 32'(slice_tick), 32'h1);
    check("sim_gnt_tick", 32'(gnt), 32'h1);
    req = 4'b0100;
    step();
    check("sim_idle_gnt", 32'(gnt), 32'h0);
    check("sim_idle_busy", 32'(busy), 32'h0);
    check("sim_idle_tick", 32'(slice_tick), 32'h0);
    step();
    check("sim_gnt2", 32'(gnt), 32'h4);

    // Reset mid-grant; round robin must restart at index 0.
    step(5);
    rst = 1'b1; req = 4'b1111;
    step();
    check("mid_rst_gnt", 32'(gnt), 32'h0);
    check("mid_rst_busy", 32'(busy), 32'h0);
    check("mid_rst_leds", 32'(LEDS), 32'h0);
    check("mid_rst_owner", 32'(owner), 32'h0);
    rst = 1'b0;
    step();
    check("mid_rst_rr", 32'(gnt), 32'h1);
    check("mid_rst_rr_owner", 32'(owner), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
